// File: rtl/out_port_demux.sv
`default_nettype none
// ============================================================================
// Module      : out_port_demux
// Description : One-entry registered 1:2 demultiplexer with valid/ready
//               handshakes and per-port delivery counters.
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_demux #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             S,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O0,
    output logic             O0_valid,
    input  logic             O0_ready,
    output logic [WIDTH-1:0] O1,
    output logic             O1_valid,
    input  logic             O1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_d;
    logic             r_sd;
    logic [CNTW-1:0]  r_cnt0;
    logic [CNTW-1:0]  r_cnt1;

    logic w_full;
    logic w_fire0;
    logic w_fire1;
    logic w_out_fire;
    logic w_in_fire;

    // Ready of the non-selected port never contributes to a fire.
    assign w_full     = (r_state == ST_FULL);
    assign w_fire0    = w_full && !r_sd && O0_ready;
    assign w_fire1    = w_full &&  r_sd && O1_ready;
    assign w_out_fire = w_fire0 || w_fire1;
    assign w_in_fire  = I_valid && I_ready;

    assign I_ready  = !w_full || w_out_fire;
    assign O0       = r_d;
    assign O1       = r_d;
    assign O0_valid = w_full && !r_sd;
    assign O1_valid = w_full &&  r_sd;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
            r_d     <= '0;
            r_sd    <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Select travels with its word; a held word is never redirected.
            if (w_in_fire) begin
                r_d  <= I;
                r_sd <= S;
            end
            if (w_fire0) begin
                r_cnt0 <= r_cnt0 + c_CNT_ONE;
            end
            if (w_fire1) begin
                r_cnt1 <= r_cnt1 + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_out_fire && !w_in_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_out_port_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_demux
// Description : Self-checking bench for out_port_demux (vector table plus
//               scoreboard-driven streaming and counter wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_demux;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] I;
    logic        S;
    logic        I_valid;
    logic        I_ready;
    logic [15:0] O0;
    logic        O0_valid;
    logic        O0_ready;
    logic [15:0] O1;
    logic        O1_valid;
    logic        O1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int nvec = 0;
    int nmis = 0;

    out_port_demux #(.WIDTH(16), .CNTW(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .I        (I),
        .S        (S),
        .I_valid  (I_valid),
        .I_ready  (I_ready),
        .O0       (O0),
        .O0_valid (O0_valid),
        .O0_ready (O0_ready),
        .O1       (O1),
        .O1_valid (O1_valid),
        .O1_ready (O1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [15:0] i;
        logic        s;
        logic        iv;
        logic        r0;
        logic        r1;
        logic        chk;
        logic        e_ir;
        logic        e_v0;
        logic        e_v1;
        logic [15:0] e_d;
        logic [15:0] e_c0;
        logic [15:0] e_c1;
    } vec_t;

    typedef struct {
        logic        s;
        logic [15:0] d;
    } sb_t;

    vec_t        tbl [18];
    sb_t         sbq [$];
    logic [15:0] ecnt0;
    logic [15:0] ecnt1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; I_valid = 1'b0; O0_ready = 1'b1; O1_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        sbq.delete();
        ecnt0 = '0;
        ecnt1 = '0;
    endtask

    // Words base..base+n-1 streamed with both readies high; expected words are
    // queued on drive and popped when the held word must be leaving.
    task automatic run_stream(input int n, input bit alt, input logic [15:0] base);
        int   sent;
        int   guard;
        sb_t  e;
        sb_t  nw;
        sent  = 0;
        guard = 0;
        while ((sent < n || sbq.size() != 0) && guard < n + 20) begin
            @(negedge CLK);
            O0_ready = 1'b1;
            O1_ready = 1'b1;
            if (sent < n) begin
                I_valid = 1'b1;
                I       = base + 16'(sent);
                S       = alt ? sent[0] : 1'b0;
            end else begin
                I_valid = 1'b0;
            end
            #1;
            check("stream_cnt0", {16'h0, cnt0}, {16'h0, ecnt0});
            check("stream_cnt1", {16'h0, cnt1}, {16'h0, ecnt1});
            check("stream_i_ready", {31'h0, I_ready}, 32'h1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("stream_o0_valid", {31'h0, O0_valid}, {31'h0, !e.s});
                check("stream_o1_valid", {31'h0, O1_valid}, {31'h0, e.s});
                check("stream_data", {16'h0, (e.s ? O1 : O0)}, {16'h0, e.d});
                if (e.s) ecnt1 = ecnt1 + 16'h1;
                else     ecnt0 = ecnt0 + 16'h1;
            end else begin
                check("stream_idle_valid", {30'h0, O0_valid, O1_valid}, 32'h0);
            end
            if (sent < n) begin
                nw.s = S;
                nw.d = I;
                sbq.push_back(nw);
                sent++;
            end
            guard++;
        end
        if (guard >= n + 20) begin
            check("stream_timeout", 32'h1, 32'h0);
        end
        @(negedge CLK);
        I_valid = 1'b0;
        #1;
        check("stream_end_cnt0", {16'h0, cnt0}, {16'h0, ecnt0});
        check("stream_end_cnt1", {16'h0, cnt1}, {16'h0, ecnt1});
    endtask

    initial begin
        RST = 1'b1; I = 16'hBEEF; S = 1'b0; I_valid = 1'b1;
        O0_ready = 1'b1; O1_ready = 1'b1;

        //         rst  i         s     iv    r0    r1    chk   ir    v0    v1    d         c0     c1
        tbl[0]  = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0};
        // single transfer to port 1
        tbl[3]  = '{1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'd0, 16'd0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'd0, 16'd1};
        // backpressure on port 0; port 1 ready and a redirect attempt are ignored
        tbl[6]  = '{1'b0, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'd0, 16'd1};
        for (int k = 7; k <= 11; k++) begin
            tbl[k] = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5A5, 16'd0, 16'd1};
        end
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'd0, 16'd1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'd1, 16'd1};
        // reset while a port-1 word is stalled
        tbl[14] = '{1'b0, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'd1, 16'd1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'd1, 16'd1};
        tbl[16] = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'd1, 16'd1};
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0};

        for (int k = 0; k < 18; k++) begin
            @(negedge CLK);
            RST      = tbl[k].rst;
            I        = tbl[k].i;
            S        = tbl[k].s;
            I_valid  = tbl[k].iv;
            O0_ready = tbl[k].r0;
            O1_ready = tbl[k].r1;
            #1;
            if (tbl[k].chk) begin
                check($sformatf("vec%0d_i_ready", k), {31'h0, I_ready}, {31'h0, tbl[k].e_ir});
                check($sformatf("vec%0d_o0_valid", k), {31'h0, O0_valid}, {31'h0, tbl[k].e_v0});
                check($sformatf("vec%0d_o1_valid", k), {31'h0, O1_valid}, {31'h0, tbl[k].e_v1});
                check($sformatf("vec%0d_o0", k), {16'h0, O0}, {16'h0, tbl[k].e_d});
                check($sformatf("vec%0d_o1", k), {16'h0, O1}, {16'h0, tbl[k].e_d});
                check($sformatf("vec%0d_cnt0", k), {16'h0, cnt0}, {16'h0, tbl[k].e_c0});
                check($sformatf("vec%0d_cnt1", k), {16'h0, cnt1}, {16'h0, tbl[k].e_c1});
            end
        end

        // Alternating stream 0x0001..0x0008 with no bubbles.
        do_reset();
        run_stream(8, 1'b1, 16'h0001);
        check("alt_final_cnt0", {16'h0, cnt0}, 32'h4);
        check("alt_final_cnt1", {16'h0, cnt1}, 32'h4);

        // Counter wrap on port 0.
        do_reset();
        run_stream(65535, 1'b0, 16'h0000);
        check("wrap_cnt0_max", {16'h0, cnt0}, 32'hFFFF);
        check("wrap_cnt1_max", {16'h0, cnt1}, 32'h0);
        run_stream(1, 1'b0, 16'hCAFE);
        check("wrap_cnt0_zero", {16'h0, cnt0}, 32'h0);
        check("wrap_cnt1_zero", {16'h0, cnt1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
